cmod_s7_btn: RTL and testbench

Input-side companion to the board LED driver on the Digilent Cmod S7. The block takes the raw, asynchronous, bouncing push-button pins and produces clean per-button signals for the fabric:

- a synchronized, debounced level;
- single-cycle press and release strobes;
- a single-cycle long-press strobe.

It sits directly behind the top-level button pins and feeds control logic in the same clock domain.

---
 rtl/cmod_s7_btn.sv | 118 +++++++++++
 tb/tb_cmod_s7_btn.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cmod_s7_btn.sv
// Push-button front end: per-button 2-flop synchronizer, debounce, and
// registered press/release/long-press strobes.

module cmod_s7_btn_ch #(
    parameter int DB_CYC   = 10,
    parameter int HOLD_CYC = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);
    localparam int DW = $clog2(DB_CYC);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          btn_q, btn_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          hold_q, hold_d;

    always_comb begin
        db_cnt_d  = '0;
        btn_d     = btn_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != btn_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_d     = ~btn_q;
                press_d   = ~btn_q;
                release_d = btn_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Counting only while the level is 1 now and next cycle: this clears
        // on the rising edge and abandons a hold that coincides with release.
        hold_cnt_d = '0;
        hold_d     = 1'b0;
        if (btn_q && btn_d) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                hold_d     = (hold_cnt_q == HOLD_LAST);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            btn_q      <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            btn_q      <= btn_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
        end
    end

    assign btn_o     = btn_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign hold_o    = hold_q;
endmodule

module cmod_s7_btn #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int HOLD_MS     = 1000,
    parameter int NUM_BTN     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] btn_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] hold_o
);
    localparam int DEBOUNCE_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int HOLD_CYC     = CLK_FREQ / 1000 * HOLD_MS;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        cmod_s7_btn_ch #(
            .DB_CYC  (DEBOUNCE_CYC),
            .HOLD_CYC(HOLD_CYC)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn_i[g]),
            .btn_o    (btn_o[g]),
            .press_o  (press_o[g]),
            .release_o(release_o[g]),
            .hold_o   (hold_o[g])
        );
    end
endmodule

// File: tb/tb_cmod_s7_btn.sv
// Bench for cmod_s7_btn: directed scenarios plus random bouncing, checked
// each cycle against a run-length/timestamp model of the button behaviour.

module tb_cmod_s7_btn;
    localparam int D = 10;
    localparam int H = 50;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_i;
    logic [N-1:0] btn_o, press_o, release_o, hold_o;

    cmod_s7_btn #(
        .CLK_FREQ   (10_000),
        .DEBOUNCE_MS(1),
        .HOLD_MS    (5),
        .NUM_BTN    (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_i    (btn_i),
        .btn_o    (btn_o),
        .press_o  (press_o),
        .release_o(release_o),
        .hold_o   (hold_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: input seen by the debouncer is btn_i delayed two edges; the
    // level flips once a mismatch run reaches D; hold fires H edges after rise.
    logic [N-1:0] m_d1, m_d2, m_lvl, m_press, m_rel, m_hold;
    int           m_run[N];
    int           m_rise[N];
    int           ncyc = 0;

    // Observed-strobe bookkeeping for directed latency checks.
    int pcnt[N], rcnt[N], hcnt[N], lp[N], lr[N], lh[N];

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_lvl = '0;
        m_press = '0; m_rel = '0; m_hold = '0;
        for (int b = 0; b < N; b++) begin
            m_run[b] = 0; m_rise[b] = 0;
        end
    endtask

    task automatic model_step();
        logic seen;
        ncyc++;
        for (int b = 0; b < N; b++) begin
            seen = m_d2[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = btn_i[b];
            m_press[b] = 1'b0;
            m_rel[b] = 1'b0;
            if (seen != m_lvl[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == D) begin
                m_run[b] = 0;
                m_lvl[b] = ~m_lvl[b];
                if (m_lvl[b]) begin
                    m_press[b] = 1'b1;
                    m_rise[b] = ncyc;
                end else begin
                    m_rel[b] = 1'b1;
                end
            end
            m_hold[b] = m_lvl[b] && (ncyc - m_rise[b] == H);
        end
    endtask

    task automatic check_all();
        chk("btn_o", int'(btn_o), int'(m_lvl));
        chk("press_o", int'(press_o), int'(m_press));
        chk("release_o", int'(release_o), int'(m_rel));
        chk("hold_o", int'(hold_o), int'(m_hold));
    endtask

    task automatic clr_counts();
        for (int b = 0; b < N; b++) begin
            pcnt[b] = 0; rcnt[b] = 0; hcnt[b] = 0;
            lp[b] = -1000; lr[b] = -1000; lh[b] = -1000;
        end
    endtask

    // One clock: drive at negedge, step model at posedge, check at negedge.
    task automatic cyc(input logic [N-1:0] b);
        btn_i = b;
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (press_o[i])   begin pcnt[i]++; lp[i] = ncyc; end
                if (release_o[i]) begin rcnt[i]++; lr[i] = ncyc; end
                if (hold_o[i])    begin hcnt[i]++; lh[i] = ncyc; end
            end
        end
    endtask

    // Assert reset mid-cycle and confirm outputs clear before any clock edge.
    task automatic apply_reset(input int n);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        repeat (n) cyc(btn_i);
        rst = 1'b0;
    endtask

    int n0;
    logic [N-1:0] rv;
    int rem[N];

    initial begin
        rst = 1'b1;
        btn_i = '0;
        model_reset();
        clr_counts();
        @(negedge clk);
        check_all();
        repeat (3) cyc('0);
        rst = 1'b0;
        repeat (3) cyc('0);

        // Clean press, then long hold and release.
        clr_counts();
        n0 = ncyc + 1;
        repeat (15) cyc(2'b01);
        chk("s1_press_lat", lp[0] - n0, 11);
        chk("s1_press_cnt", pcnt[0], 1);
        chk("s1_btn1_quiet", pcnt[1] + rcnt[1] + hcnt[1], 0);
        repeat (100) cyc(2'b01);
        chk("s3_hold_lat", lh[0] - lp[0], H);
        chk("s3_hold_cnt", hcnt[0], 1);
        n0 = ncyc + 1;
        repeat (15) cyc(2'b00);
        chk("s3_rel_lat", lr[0] - n0, 11);
        chk("s3_hold_cnt2", hcnt[0], 1);
        repeat (5) cyc(2'b00);

        // Bounce then short press.
        clr_counts();
        repeat (3) cyc(2'b01);
        repeat (5) cyc(2'b00);
        repeat (9) cyc(2'b01);
        repeat (3) cyc(2'b00);
        chk("s2_no_strobe", pcnt[0] + rcnt[0], 0);
        n0 = ncyc + 1;
        repeat (12) cyc(2'b01);
        chk("s2_press_lat", lp[0] - n0, 11);
        chk("s2_press_cnt", pcnt[0], 1);
        repeat (30) cyc(2'b01);
        repeat (20) cyc(2'b00);
        chk("s4_rel_cnt", rcnt[0], 1);
        chk("s4_no_hold", hcnt[0], 0);

        // Both buttons together, then reset while held.
        clr_counts();
        n0 = ncyc + 1;
        repeat (15) cyc(2'b11);
        chk("s5_press0_lat", lp[0] - n0, 11);
        chk("s5_same_cycle", lp[1] - lp[0], 0);
        repeat (8) cyc(2'b11);
        apply_reset(3);
        clr_counts();
        n0 = ncyc + 1;
        repeat (70) cyc(2'b11);
        chk("s6_press_lat", lp[0] - n0, 11);
        chk("s6_hold_lat", lh[1] - lp[1], H);
        repeat (15) cyc(2'b00);

        // Random bouncing with a mix of glitch, medium and long runs.
        rv = '0;
        for (int b = 0; b < N; b++) rem[b] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if (rem[b] == 0) begin
                    int sel;
                    sel = int'($urandom_range(0, 9));
                    rv[b] = ~rv[b];
                    if (sel < 5)      rem[b] = int'($urandom_range(1, 12));
                    else if (sel < 9) rem[b] = int'($urandom_range(10, 40));
                    else              rem[b] = int'($urandom_range(55, 90));
                end
                rem[b]--;
            end
            cyc(rv);
            if (i == 1500) apply_reset(int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
